// File: rtl/alarm_set_ctrl.sv
// alarm_set_ctrl: button-driven hour/minute entry for the alarm clock core.
// Drives the core's BCD digit inputs and stretches every load/stop command
// to LD_HOLD cycles so the core's slow 1 s domain is sure to sample it.
// Optional feature macro: ALARM_SNOOZE_EN (snooze re-ring after SNOOZE_MIN minutes).
//
//  state  | meaning
//  IDLE   | waiting for a button; alarm stop / edit entry
//  T_HR   | editing hour of the time
//  T_MIN  | editing minute of the time
//  A_HR   | editing hour of the alarm
//  A_MIN  | editing minute of the alarm
//  LOAD_T | holding LD_time for LD_HOLD cycles
//  LOAD_A | holding LD_alarm for LD_HOLD cycles
//  STOP   | holding STOP_al for LD_HOLD cycles
module alarm_set_ctrl #(
  parameter int LD_HOLD    = 16,
  parameter int TIMEOUT    = 1000,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_set,
  input  logic       btn_inc,
  input  logic       btn_mode,
  input  logic       btn_alon,
  input  logic       btn_snooze,
  input  logic       min_tick,
  input  logic       alarm_in,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       STOP_al,
  output logic       AL_ON,
  output logic       ring,
  output logic       busy
);

  localparam int HW = $clog2(LD_HOLD + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_T_HR, S_T_MIN, S_A_HR, S_A_MIN, S_LOAD_T, S_LOAD_A, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [4:0]      hour_q, hour_d;
  logic [5:0]      min_q, min_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [TW-1:0]   to_q, to_d;
  logic [1:0]      h1_q, h1_d;
  logic [3:0]      h0_q, h0_d, m1_q, m1_d, m0_q, m0_d;
  logic            ld_time_q, ld_time_d;
  logic            ld_alarm_q, ld_alarm_d;
  logic            stop_al_q, stop_al_d;
  logic            al_on_q, al_on_d;
  logic            ring_q, ring_d;
  logic            btn_any;
  logic            edit_timeout;
  logic            snooze_req;

`ifdef ALARM_SNOOZE_EN
  logic [3:0]      snz_cnt_q, snz_cnt_d;
  logic            snz_act_q, snz_act_d;
  logic            snz_ring_q, snz_ring_d;

  assign btn_any    = btn_set | btn_inc | btn_mode | btn_alon | btn_snooze;
  // Snooze only acts when nothing of higher priority was pressed.
  assign snooze_req = btn_snooze & ring_q & ~btn_set & ~btn_mode;
`else
  logic            unused_snooze_inputs;

  assign unused_snooze_inputs = btn_snooze ^ min_tick;
  assign btn_any    = btn_set | btn_inc | btn_mode | btn_alon;
  assign snooze_req = 1'b0;
`endif

  // The idle timer has expired only if no button arrives in this same cycle.
  assign edit_timeout = (to_q == '0) && !btn_any;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; mode beats set beats inc.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (btn_mode)      state_d = S_A_HR;
        else if (btn_set)  state_d = alarm_in ? S_STOP : S_T_HR;
        else if (snooze_req) state_d = S_STOP;
      end
      S_T_HR: begin
        if (btn_mode)          state_d = S_IDLE;
        else if (btn_set)      state_d = S_T_MIN;
        else if (edit_timeout) state_d = S_IDLE;
      end
      S_T_MIN: begin
        if (btn_mode)          state_d = S_IDLE;
        else if (btn_set)      state_d = S_LOAD_T;
        else if (edit_timeout) state_d = S_IDLE;
      end
      S_A_HR: begin
        if (btn_mode)          state_d = S_IDLE;
        else if (btn_set)      state_d = S_A_MIN;
        else if (edit_timeout) state_d = S_IDLE;
      end
      S_A_MIN: begin
        if (btn_mode)          state_d = S_IDLE;
        else if (btn_set)      state_d = S_LOAD_A;
        else if (edit_timeout) state_d = S_IDLE;
      end
      S_LOAD_T, S_LOAD_A, S_STOP: begin
        if (hold_q == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Edit registers, command hold timer and idle timer.
  always_comb begin
    hour_d = hour_q;
    min_d  = min_q;
    hold_d = hold_q;
    to_d   = to_q;

    if (state_q == S_IDLE && (state_d == S_T_HR || state_d == S_A_HR)) begin
      hour_d = '0;
      min_d  = '0;
    end else if (btn_inc && !btn_set && !btn_mode) begin
      if (state_q == S_T_HR || state_q == S_A_HR)
        hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
      else if (state_q == S_T_MIN || state_q == S_A_MIN)
        min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
    end

    // Loaded with LD_HOLD-1 so the state lasts exactly LD_HOLD cycles.
    if (state_d != state_q &&
        (state_d == S_LOAD_T || state_d == S_LOAD_A || state_d == S_STOP))
      hold_d = HW'(LD_HOLD - 1);
    else if (hold_q != '0)
      hold_d = hold_q - 1'b1;

    if (btn_any || state_d != state_q) to_d = TW'(TIMEOUT - 1);
    else if (to_q != '0)               to_d = to_q - 1'b1;
  end

  // Registered outputs: commands lag the state by one cycle, digits lag the edit regs.
  always_comb begin
    ld_time_d  = (state_q == S_LOAD_T);
    ld_alarm_d = (state_q == S_LOAD_A);
    stop_al_d  = (state_q == S_STOP);
    al_on_d    = al_on_q ^ btn_alon;
`ifdef ALARM_SNOOZE_EN
    ring_d     = alarm_in | snz_ring_q;
`else
    ring_d     = alarm_in;
`endif

    // Tens by range compare; units by 4-bit subtract of (10*tens mod 16).
    if (hour_q >= 5'd20)      begin h1_d = 2'd2; h0_d = hour_q[3:0] - 4'd4;  end
    else if (hour_q >= 5'd10) begin h1_d = 2'd1; h0_d = hour_q[3:0] - 4'd10; end
    else                      begin h1_d = 2'd0; h0_d = hour_q[3:0];         end

    if (min_q >= 6'd50)      begin m1_d = 4'd5; m0_d = min_q[3:0] - 4'd2;  end
    else if (min_q >= 6'd40) begin m1_d = 4'd4; m0_d = min_q[3:0] - 4'd8;  end
    else if (min_q >= 6'd30) begin m1_d = 4'd3; m0_d = min_q[3:0] - 4'd14; end
    else if (min_q >= 6'd20) begin m1_d = 4'd2; m0_d = min_q[3:0] - 4'd4;  end
    else if (min_q >= 6'd10) begin m1_d = 4'd1; m0_d = min_q[3:0] - 4'd10; end
    else                     begin m1_d = 4'd0; m0_d = min_q[3:0];         end
  end

`ifdef ALARM_SNOOZE_EN
  // Snooze countdown: armed by an accepted snooze, re-rings when it reaches zero.
  always_comb begin
    snz_cnt_d  = snz_cnt_q;
    snz_act_d  = snz_act_q;
    snz_ring_d = snz_ring_q;
    if ((state_q == S_IDLE && btn_set) || (al_on_q && btn_alon)) begin
      snz_cnt_d  = '0;
      snz_act_d  = 1'b0;
      snz_ring_d = 1'b0;
    end else if (state_q == S_IDLE && snooze_req) begin
      snz_cnt_d  = 4'(SNOOZE_MIN);
      snz_act_d  = 1'b1;
      snz_ring_d = 1'b0;
    end else if (snz_act_q && min_tick) begin
      snz_cnt_d = snz_cnt_q - 4'd1;
      if (snz_cnt_q == 4'd1) begin
        snz_act_d  = 1'b0;
        snz_ring_d = 1'b1;
      end
    end
  end

  // Snooze registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snz_cnt_q  <= '0;
      snz_act_q  <= 1'b0;
      snz_ring_q <= 1'b0;
    end else begin
      snz_cnt_q  <= snz_cnt_d;
      snz_act_q  <= snz_act_d;
      snz_ring_q <= snz_ring_d;
    end
  end
`endif

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hour_q     <= '0;
      min_q      <= '0;
      hold_q     <= '0;
      to_q       <= '0;
      h1_q       <= '0;
      h0_q       <= '0;
      m1_q       <= '0;
      m0_q       <= '0;
      ld_time_q  <= 1'b0;
      ld_alarm_q <= 1'b0;
      stop_al_q  <= 1'b0;
      al_on_q    <= 1'b0;
      ring_q     <= 1'b0;
    end else begin
      hour_q     <= hour_d;
      min_q      <= min_d;
      hold_q     <= hold_d;
      to_q       <= to_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      m1_q       <= m1_d;
      m0_q       <= m0_d;
      ld_time_q  <= ld_time_d;
      ld_alarm_q <= ld_alarm_d;
      stop_al_q  <= stop_al_d;
      al_on_q    <= al_on_d;
      ring_q     <= ring_d;
    end
  end

  assign H_in1    = h1_q;
  assign H_in0    = h0_q;
  assign M_in1    = m1_q;
  assign M_in0    = m0_q;
  assign LD_time  = ld_time_q;
  assign LD_alarm = ld_alarm_q;
  assign STOP_al  = stop_al_q;
  assign AL_ON    = al_on_q;
  assign ring     = ring_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Bench for alarm_set_ctrl: a table of single-cycle vectors followed by
// hand-written multi-cycle sequences (loads, wraps, timeout, stop, reset).
module tb_alarm_set_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       btn_set = 1'b0, btn_inc = 1'b0, btn_mode = 1'b0, btn_alon = 1'b0;
  logic       btn_snooze = 1'b0, min_tick = 1'b0, alarm_in = 1'b0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, STOP_al, AL_ON, ring, busy;

  int n_vec  = 0;
  int n_miss = 0;

  alarm_set_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .btn_set(btn_set), .btn_inc(btn_inc), .btn_mode(btn_mode), .btn_alon(btn_alon),
    .btn_snooze(btn_snooze), .min_tick(min_tick), .alarm_in(alarm_in),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .STOP_al(STOP_al),
    .AL_ON(AL_ON), .ring(ring), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       set, inc, mode, alon, alm;
    logic [19:0] exp; // busy,al_on,ring,ld_t,ld_a,stop,h1[2],h0[4],m1[4],m0[4]
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(input string nm, input logic s, input logic i,
                              input logic m, input logic a, input logic al,
                              input logic bz, input logic ao, input logic rg,
                              input logic [1:0] h1, input logic [3:0] h0,
                              input logic [3:0] m1, input logic [3:0] m0);
    vec_t v;
    v.name = nm; v.set = s; v.inc = i; v.mode = m; v.alon = a; v.alm = al;
    v.exp  = {bz, ao, rg, 3'b000, h1, h0, m1, m0};
    return v;
  endfunction

  function automatic logic [19:0] outs();
    return {busy, AL_ON, ring, LD_time, LD_alarm, STOP_al, H_in1, H_in0, M_in1, M_in0};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_btns();
    btn_set = 0; btn_inc = 0; btn_mode = 0; btn_alon = 0; btn_snooze = 0; min_tick = 0;
  endtask

  // 0=set 1=inc 2=mode
  task automatic pulse(input int which, input int times);
    for (int k = 0; k < times; k++) begin
      case (which)
        0: btn_set = 1;
        1: btn_inc = 1;
        default: btn_mode = 1;
      endcase
      tick();
      clear_btns();
    end
  endtask

  initial begin
    int cnt_t, cnt_a, cnt_s, bad_dig, guard;

    //                set inc mode alon alm  busy alon ring  h1 h0 m1 m0
    vecs[0]  = mk("reset",      0,0,0,0,0, 0,0,0, 0,0,0,0);
    vecs[1]  = mk("alon_on",    0,0,0,1,0, 0,1,0, 0,0,0,0);
    vecs[2]  = mk("ring_up",    0,0,0,0,1, 0,1,1, 0,0,0,0);
    vecs[3]  = mk("ring_dn",    0,0,0,0,0, 0,1,0, 0,0,0,0);
    vecs[4]  = mk("alon_off",   0,0,0,1,0, 0,0,0, 0,0,0,0);
    vecs[5]  = mk("enter_t",    1,0,0,0,0, 1,0,0, 0,0,0,0);
    vecs[6]  = mk("inc_hr",     0,1,0,0,0, 1,0,0, 0,0,0,0);
    vecs[7]  = mk("hr_disp",    0,0,0,0,0, 1,0,0, 0,1,0,0);
    vecs[8]  = mk("set_inc",    1,1,0,0,0, 1,0,0, 0,1,0,0);
    vecs[9]  = mk("inc_min",    0,1,0,0,0, 1,0,0, 0,1,0,0);
    vecs[10] = mk("min_disp",   0,0,0,0,0, 1,0,0, 0,1,0,1);
    vecs[11] = mk("abort",      0,0,1,0,0, 0,0,0, 0,1,0,1);
    vecs[12] = mk("idle_inc",   0,1,0,0,0, 0,0,0, 0,1,0,1);
    vecs[13] = mk("mode_set",   1,0,1,0,0, 1,0,0, 0,1,0,1);
    vecs[14] = mk("a_clear",    0,0,0,0,0, 1,0,0, 0,0,0,0);
    vecs[15] = mk("inc_mode",   0,1,1,0,0, 0,0,0, 0,0,0,0);
    vecs[16] = mk("after_ab",   0,0,0,0,0, 0,0,0, 0,0,0,0);

    repeat (3) tick();
    reset_n = 1;

    foreach (vecs[i]) begin
      btn_set = vecs[i].set; btn_inc = vecs[i].inc; btn_mode = vecs[i].mode;
      btn_alon = vecs[i].alon; alarm_in = vecs[i].alm;
      tick();
      clear_btns();
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
    end
    alarm_in = 0;

    // Time load 07:30, with ignored buttons during the hold.
    pulse(0, 1); pulse(1, 7); pulse(0, 1); pulse(1, 30); pulse(0, 1);
    cnt_t = 0; cnt_a = 0; cnt_s = 0; bad_dig = 0;
    for (int c = 0; c < 30; c++) begin
      if (c == 3) begin btn_mode = 1; btn_inc = 1; btn_set = 1; end
      tick();
      clear_btns();
      if (LD_time) begin
        cnt_t++;
        if ({H_in1, H_in0, M_in1, M_in0} != {2'd0, 4'd7, 4'd3, 4'd0}) bad_dig++;
      end
      if (LD_alarm) cnt_a++;
      if (STOP_al) cnt_s++;
    end
    chk("ldt_len", 32'(cnt_t), 32'd16);
    chk("ldt_digits", 32'(bad_dig), 32'd0);
    chk("ldt_other_cmd", 32'(cnt_a + cnt_s), 32'd0);
    chk("ldt_busy_end", 32'(busy), 32'd0);

    // Alarm load with both fields wrapping to 00:00.
    pulse(2, 1); pulse(1, 24); pulse(0, 1); pulse(1, 60); pulse(0, 1);
    cnt_t = 0; cnt_a = 0; bad_dig = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (LD_alarm) begin
        cnt_a++;
        if ({H_in1, H_in0, M_in1, M_in0} != 14'd0) bad_dig++;
      end
      if (LD_time) cnt_t++;
    end
    chk("lda_len", 32'(cnt_a), 32'd16);
    chk("lda_wrap_digits", 32'(bad_dig), 32'd0);
    chk("lda_no_ldt", 32'(cnt_t), 32'd0);

    // Edit timeout: 1000 idle cycles abandon without load.
    pulse(0, 1); pulse(1, 3);
    cnt_t = 0;
    for (int c = 0; c < 999; c++) begin
      tick();
      if (LD_time | LD_alarm) cnt_t++;
    end
    chk("to_busy_999", 32'(busy), 32'd1);
    chk("to_digits", 32'({H_in1, H_in0}), 32'h03);
    tick();
    chk("to_busy_1000", 32'(busy), 32'd0);
    chk("to_no_load", 32'(cnt_t), 32'd0);
    pulse(0, 1);
    tick();
    chk("to_restart", 32'({busy, H_in1, H_in0, M_in1, M_in0}), 32'h4000);
    pulse(2, 1);

    // Stop alarm from IDLE.
    alarm_in = 1;
    pulse(0, 1);
    alarm_in = 0;
    cnt_t = 0; cnt_s = 0;
    for (int c = 0; c < 25; c++) begin
      tick();
      if (STOP_al) cnt_s++;
      if (LD_time | LD_alarm) cnt_t++;
    end
    chk("stop_len", 32'(cnt_s), 32'd16);
    chk("stop_no_load", 32'(cnt_t), 32'd0);
    chk("stop_idle", 32'(busy), 32'd0);

    // Reset during the fifth LD_time cycle.
    pulse(0, 3);
    cnt_t = 0; guard = 0;
    while (cnt_t < 5 && guard < 12) begin
      tick();
      guard++;
      if (LD_time) cnt_t++;
    end
    chk("rst_reach_c5", 32'(cnt_t), 32'd5);
    #1 reset_n = 0;
    #1 chk("rst_drop", 32'({LD_time, busy}), 32'd0);
    @(negedge clk);
    reset_n = 1;
    cnt_t = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (LD_time) cnt_t++;
    end
    chk("rst_no_reissue", 32'(cnt_t), 32'd0);
    chk("rst_idle", 32'(busy), 32'd0);

`ifdef ALARM_SNOOZE_EN
    alarm_in = 1;
    tick();
    btn_snooze = 1;
    tick();
    clear_btns();
    alarm_in = 0;
    repeat (20) tick();
    chk("snz_quiet", 32'(ring), 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 4) chk("snz_before5", 32'(ring), 32'd0);
      min_tick = 1;
      tick();
      clear_btns();
      tick();
    end
    chk("snz_ring", 32'(ring), 32'd1);
    pulse(0, 1);
    tick();
    chk("snz_clear", 32'(ring), 32'd0);
    pulse(2, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
